// File: rtl/inst_rom_loader_pkg.sv
// Shared instruction-bus definitions for the instruction ROM and its boot loader.
package inst_rom_loader_pkg;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W = 32;
    localparam int INST_MEM_NUM_LOG2 = 10;

    typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;
    typedef logic [INST_BUS_W-1:0] inst_t;

    localparam inst_t ZERO_WORD = '0;
    localparam logic CHIP_ENABLE = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module inst_rom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = INST_MEM_NUM_LOG2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  inst_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output inst_t             rdata
);

    inst_t mem [2**ADDR_W];

    // NOTE: the array has no reset; clearing it would turn it into a huge
    // reset fan-out and forbid RAM mapping, and contents must survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream boot loader; holds the CPU in reset until loaded.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W     = INST_MEM_NUM_LOG2,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rom_ce_i,
    input  inst_addr_t rom_addr_i,
    output inst_t      rom_data_o,
    input  logic       ld_valid_i,
    input  logic [7:0] ld_byte_i,
    input  logic       ld_last_i,
    output logic       ld_ready_o,
    output logic       cpu_rst_o,
    output logic       load_done_o,
    output logic       load_err_o
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic              full_q;
    inst_t             shift_q;
    logic              cpu_rst_q, done_q, err_q;

    logic              xfer, we;
    logic [4:0]        pad_bits;
    inst_t             shifted, wdata, rdata;
    logic              in_range;
    logic              unused_addr_bits;

    // Bytes already in the shift register that belong to an older word fall
    // off the end, so a partial last word is padded with zeros by the shift.
    assign pad_bits = {2'd3 - byte_cnt_q, 3'b000};

    always_comb begin
        if (BIG_ENDIAN) begin
            shifted = {shift_q[23:0], ld_byte_i};
            wdata   = shifted << pad_bits;
        end else begin
            shifted = {ld_byte_i, shift_q[31:8]};
            wdata   = shifted >> pad_bits;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        ld_ready_o = 1'b0;
        we         = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ld_ready_o = (rst != RST_ENABLE);
                if (ld_valid_i && ld_ready_o) begin
                    we = !full_q && ((byte_cnt_q == 2'd3) || ld_last_i);
                    if (ld_last_i) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: ;
        endcase
    end

    assign xfer = ld_valid_i && ld_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            full_q     <= 1'b0;
            shift_q    <= ZERO_WORD;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= shifted;
            if (we) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (&wr_ptr_q) begin
                    full_q <= 1'b1;
                end
            end
            if (full_q) begin
                err_q <= 1'b1;
            end
            if (ld_last_i) begin
                cpu_rst_q <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    assign cpu_rst_o   = cpu_rst_q;
    assign load_done_o = done_q;
    assign load_err_o  = err_q;

    inst_rom_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rom_addr_i[ADDR_W+1:2]),
        .rdata (rdata)
    );

    // Byte offset within a word is meaningless for a word-wide fetch.
    assign unused_addr_bits = ^rom_addr_i[1:0];
    assign in_range = (rom_addr_i[31:ADDR_W+2] == '0);
    assign rom_data_o = (rom_ce_i == CHIP_ENABLE && state_q == ST_RUN && in_range)
                        ? rdata : ZERO_WORD;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench: one stream drives a 1024-word big-endian and a 4-word little-endian loader.
module tb_inst_rom_loader;

    logic        clk, rst;
    logic        ce;
    logic [31:0] addr;
    logic        ld_valid, ld_last;
    logic [7:0]  ld_byte;
    logic [31:0] data_b, data_s;
    logic        ready_b, cpu_rst_b, done_b, err_b;
    logic        ready_s, cpu_rst_s, done_s, err_s;

    int checks = 0;
    int errors = 0;

    inst_rom_loader #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(data_b),
        .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
        .ld_ready_o(ready_b), .cpu_rst_o(cpu_rst_b), .load_done_o(done_b),
        .load_err_o(err_b)
    );

    inst_rom_loader #(.ADDR_W(2), .BIG_ENDIAN(1'b0)) dut_s (
        .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(data_s),
        .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
        .ld_ready_o(ready_s), .cpu_rst_o(cpu_rst_s), .load_done_o(done_s),
        .load_err_o(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: image bytes plus expected memory images of both instances.
    logic [7:0]  img[$];
    logic [31:0] mb[1024];
    bit          vb[1024];
    logic [31:0] ms[4];
    bit          vs[4];
    bit          eb, es;
    int          max_w = 0;

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp_b;
        logic [31:0] exp_s;
    } fetch_vec_t;

    fetch_vec_t vec[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int w, input bit be);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            b = (4 * w + k < img.size()) ? img[4 * w + k] : 8'h00;
            if (be) r[31 - 8 * k -: 8] = b;
            else    r[8 * k +: 8] = b;
        end
        return r;
    endfunction

    task automatic model_apply(input bit finish);
        int n, nw;
        n  = img.size();
        nw = finish ? (n + 3) / 4 : n / 4;
        for (int w = 0; w < nw; w++) begin
            if (w < 1024) begin mb[w] = pack(w, 1'b1); vb[w] = 1'b1; end
            if (w < 4)    begin ms[w] = pack(w, 1'b0); vs[w] = 1'b1; end
        end
        if (n > 4096) eb = 1'b1;
        if (n > 16)   es = 1'b1;
        if (nw > max_w) max_w = (nw > 1024) ? 1024 : nw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ce = 1'b1; addr = '0;
        #1;
        check("rst_ready_b", ready_b, 0);
        check("rst_ready_s", ready_s, 0);
        check("rst_cpu_rst", cpu_rst_b, 1);
        check("rst_done", done_b, 0);
        check("rst_err", {err_b, err_s}, 0);
        eb = 1'b0; es = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {ready_b, ready_s}, 2'b11);
        check("preload_fetch_b", data_b, 0);
        check("preload_fetch_s", data_s, 0);
        check("post_rst_cpu_rst", {cpu_rst_b, cpu_rst_s}, 2'b11);
    endtask

    // Streams img; a byte advances only on a cycle where valid is high.
    task automatic load_image(input int stall_pct, input bit finish);
        int i, cyc;
        i = 0; cyc = 0;
        while (i < img.size() && cyc < 4000) begin
            @(negedge clk);
            ld_valid = ($urandom_range(99) >= stall_pct);
            ld_byte  = ld_valid ? img[i] : 8'($urandom);
            ld_last  = ld_valid ? (finish && i == img.size() - 1) : 1'($urandom);
            check("load_ready", {ready_b, ready_s}, 2'b11);
            check("load_cpu_rst", {cpu_rst_b, cpu_rst_s}, 2'b11);
            ce   = 1'b1;
            addr = 32'($urandom_range(15)) << 2;
            #1;
            check("load_fetch_gated", data_b | data_s, 0);
            @(posedge clk);
            if (ld_valid) i++;
            cyc++;
        end
        if (cyc >= 4000) check("load_budget", cyc, 0);
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        model_apply(finish);
        if (finish) begin
            #1;
            check("run_cpu_rst", {cpu_rst_b, cpu_rst_s}, 2'b00);
            check("run_done", {done_b, done_s}, 2'b11);
            check("run_ready", {ready_b, ready_s}, 2'b00);
            check("run_err_b", err_b, eb);
            check("run_err_s", err_s, es);
        end
    endtask

    task automatic check_mem();
        for (int w = 0; w <= max_w; w++) begin
            ce   = 1'b1;
            addr = (32'(w) << 2) | 32'($urandom_range(3));
            #1;
            if (w < 1024 && vb[w]) check($sformatf("mem_b[%0d]", w), data_b, mb[w]);
            if (w >= 4) check($sformatf("mem_s_oor[%0d]", w), data_s, 0);
            else if (vs[w]) check($sformatf("mem_s[%0d]", w), data_s, ms[w]);
        end
    endtask

    task automatic stray_bytes();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_byte = 8'($urandom); ld_last = 1'($urandom);
            check("stray_ready", {ready_b, ready_s}, 2'b00);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        check("stray_done", {done_b, done_s, cpu_rst_b}, 3'b110);
        check_mem();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ce = 1'b0; addr = '0;
        ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;

        // Basic big-endian load and table-driven fetches.
        do_reset();
        img = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h07};
        load_image(0, 1'b1);
        vec[0] = '{1'b1, 32'h0000_0000, 32'h3401_0005, 32'h0500_0134};
        vec[1] = '{1'b1, 32'h0000_0004, 32'h3402_0007, 32'h0700_0234};
        vec[2] = '{1'b1, 32'h0000_0007, 32'h3402_0007, 32'h0700_0234};
        vec[3] = '{1'b1, 32'h0000_0003, 32'h3401_0005, 32'h0500_0134};
        vec[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vec[5] = '{1'b1, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000};
        for (int v = 0; v < 6; v++) begin
            ce = vec[v].ce; addr = vec[v].addr;
            #1;
            check($sformatf("vec%0d_b", v), data_b, vec[v].exp_b);
            check($sformatf("vec%0d_s", v), data_s, vec[v].exp_s);
        end

        // Partial final word is zero padded.
        do_reset();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_image(0, 1'b1);
        ce = 1'b1; addr = 32'h4;
        #1;
        check("partial_b", data_b, 32'hEE00_0000);
        check("partial_s", data_s, 32'h0000_00EE);
        check_mem();

        // Stalled 12-byte image, then stray bytes in RUN.
        do_reset();
        img.delete();
        for (int k = 0; k < 12; k++) img.push_back(8'($urandom));
        load_image(50, 1'b1);
        check_mem();
        stray_bytes();

        // Random lengths, some overflowing the small instance.
        for (int t = 0; t < 3; t++) begin
            do_reset();
            img.delete();
            for (int k = 0; k < int'($urandom_range(40, 1)); k++) img.push_back(8'($urandom));
            load_image(int'($urandom_range(60)), 1'b1);
            check_mem();
        end

        // Overflow: 20 bytes into a 4-word memory.
        do_reset();
        img.delete();
        for (int k = 0; k < 20; k++) img.push_back(8'($urandom));
        load_image(20, 1'b1);
        check("ovf_err_s", err_s, 1);
        check("ovf_err_b", err_b, 0);
        check_mem();

        // Reset mid-load after 6 bytes, then reload one word.
        do_reset();
        img.delete();
        for (int k = 0; k < 6; k++) img.push_back(8'($urandom));
        load_image(0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_cpu_rst", {cpu_rst_b, cpu_rst_s}, 2'b11);
        check("midrst_ready", {ready_b, ready_s}, 2'b00);
        check("midrst_done", {done_b, done_s}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        eb = 1'b0; es = 1'b0;
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_image(0, 1'b1);
        ce = 1'b1; addr = 32'h0;
        #1;
        check("reload_w0_b", data_b, 32'h1122_3344);
        check("reload_w0_s", data_s, 32'h4433_2211);
        max_w = 4;
        check_mem();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Responder end of the CPU instruction-fetch interface: rom_ce/rom_addr in, rom_data out.
- Holds a word-addressed instruction memory and a boot-loader front end.
- The loader accepts a big-endian byte stream over a valid/ready handshake, packs bytes into 32-bit words, and writes them sequentially from word 0.
- Holds the CPU in reset until loading completes, then serves fetches combinationally, in the same cycle, as the fetch stage requires.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2^ADDR_W words.
- BIG_ENDIAN, 1, 1 = first byte of each word goes to bits 31:24; 0 = first byte goes to bits 7:0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_ce_i  input  1  fetch enable from the CPU.
- rom_addr_i  input  32  byte address of the fetch (PC).
- rom_data_o  output  32  instruction word returned to the CPU.
- ld_valid_i  input  1  loader byte valid.
- ld_byte_i  input  8  loader byte.
- ld_last_i  input  1  marks the final byte of the image; qualified by ld_valid_i.
- ld_ready_o  output  1  block accepts a loader byte.
- cpu_rst_o  output  1  reset to the CPU core; high until the image is loaded.
- load_done_o  output  1  image loaded; memory is serving fetches.
- load_err_o  output  1  sticky overflow: the image exceeded the memory depth.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = LOAD; byte_cnt = 0; wr_ptr = 0; full = 0; shift register = 0.
  - cpu_rst_o = 1; load_done_o = 0; load_err_o = 0.
  - ld_ready_o = 0 while rst is high.
  - The memory array is not reset; contents are retained.
- Transfer definition: a byte transfers on a rising edge where ld_valid_i && ld_ready_o.
- FSM, two states:
  - LOAD:
    - ld_ready_o = 1.
    - Each transfer shifts the byte into the packer and increments byte_cnt (mod 4).
    - When byte_cnt == 3, the assembled word is written to mem[wr_ptr] on that same edge and wr_ptr increments.
  - LOAD -> RUN: on the transfer with ld_last_i = 1.
    - If byte_cnt != 3, the unfilled byte lanes are zero and the partial word is written to mem[wr_ptr] on that edge.
    - A ld_last_i byte that completes a full word writes normally.
  - RUN:
    - ld_ready_o = 0; ld_valid_i is ignored.
    - Terminal until rst.
- Output timing: cpu_rst_o and load_done_o are registered. If the last byte transfers at edge N, then after edge N cpu_rst_o = 0 and load_done_o = 1. The first valid fetch is in cycle N+1.
- Overflow:
  - When wr_ptr wraps from 2^ADDR_W-1 to 0 after a write, full is set.
  - While full, transfers are still accepted (ld_ready_o stays 1), no memory writes occur, and load_err_o is set on the first such transfer.
  - ld_last_i still moves the FSM to RUN.
  - load_err_o clears only on rst.
- Read path, combinational:
  - rom_data_o = mem[rom_addr_i[ADDR_W+1:2]] when rom_ce_i = 1, state == RUN, and rom_addr_i[31:ADDR_W+2] == 0. Otherwise rom_data_o = 0.
  - rom_addr_i[1:0] is ignored.
- Simultaneous events: a read of the word being written in the same cycle is impossible, because reads are gated by RUN and writes occur only in LOAD.
- Reset mid-load:
  - FSM, counters, and flags clear immediately; the partially packed word is discarded.
  - The next load restarts at word 0. Previously written words remain until overwritten.
- Byte order: BIG_ENDIAN=1, bytes b0..b3 -> word {b0,b1,b2,b3}; BIG_ENDIAN=0 -> {b3,b2,b1,b0}.

Decomposition:
- Shared defines file (existing): InstAddrBus (31:0), InstBus (31:0), ZeroWord, ChipEnable/ChipDisable, RstEnable. Add InstMemNumLog2 as the default for ADDR_W.
- FSM state encodings are local to this block.
- One sub-module: inst_rom_mem.
  - 2^ADDR_W x 32 register array.
  - One synchronous write port (clk, we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.

Test Plan:
- Basic load, ADDR_W=10, BIG_ENDIAN=1: stream bytes 34 01 00 05 | 34 02 00 07 (last on the final byte) -> cpu_rst_o falls one cycle after the last transfer. Fetches rom_addr_i = 0x0 and 0x4 with rom_ce_i = 1 return 0x34010005 and 0x34020007.
- Partial final word: 5 bytes AA BB CC DD EE, last on EE -> word 1 reads 0xEE000000; load_done_o = 1.
- Gating: in RUN with rom_ce_i = 0 -> rom_data_o = 0. rom_addr_i = 0x00001000 (above depth) -> 0. Before the load completes, any fetch -> 0.
- Handshake stalls: toggle ld_valid_i randomly over a 12-byte image -> only cycles with valid && ready advance. Memory matches the image; after RUN, ld_ready_o = 0 and further valid bytes cause no writes.
- Overflow, ADDR_W=2: 20 bytes, last on byte 20 -> words 0..3 hold the first 16 bytes; load_err_o = 1; still enters RUN.
- Reset mid-load: assert rst asynchronously after 6 bytes -> cpu_rst_o = 1 and ld_ready_o = 0 immediately. Reload 4 bytes 11 22 33 44 -> word 0 = 0x11223344; word 1 keeps its old contents.
